fsm_pattern_tx: RTL and testbench
=================================

# fsm_pattern_tx

Serial pattern transmitter, the driving end of the single-bit serial stream our sequence-detector FSMs consume. It captures a parallel pattern on a start request and shifts it out MSB-first, one bit per clock, with a `valid_o` qualifier. It can repeat the frame a programmable number of times with a fixed idle gap between frames. It serves as the stimulus source for detector blocks in system-level loops and as a standalone serializer.

## Interface
- `WIDTH`, 8: maximum frame length in bits; must be ≥ 2.
- `GAP`, 2: idle cycles between repeated frames; 0 means frames are back-to-back.
- `LW`, `$clog2(WIDTH)+1`: width of `len_i`.
- `clk_i` input 1: the single clock; all logic is on the rising edge.
- `reset_i` input 1: reset, synchronous and active-high.
- `start_i` input 1: transmit request; sampled only while `ready_o`=1.
- `pattern_i` input WIDTH: frame bits; `pattern_i[len-1]` is sent first.
- `len_i` input LW: frame length; 0 or any value > WIDTH is treated as WIDTH.
- `repeat_i` input 4: extra frames; total frames = `repeat_i`+1.
- `abort_i` input 1: synchronous abort of the transfer in progress.
- `data_o` output 1: serial bit; 0 whenever `valid_o`=0.
- `valid_o` output 1: `data_o` carries a frame bit.
- `ready_o` output 1: idle, able to accept `start_i`.
- `done_o` output 1: one-cycle pulse after the last bit of the last frame.

## Operation
- States, 2-bit encoding:
  - IDLE=0: `ready_o`=1.
  - SEND=1: `valid_o`=1.
  - GAP=2: `valid_o`=0, `data_o`=0.
- IDLE → SEND on `start_i`. The capture on that edge is:
  - `pattern_i` into the held pattern register;
  - effective length L into the length register;
  - `repeat_i` into the frame counter;
  - the shift register loads `pattern_i << (WIDTH-L)`, so its MSB is `pattern_i[L-1]`.
- SEND: `data_o` = shift register MSB. Each cycle the register shifts left and the bit counter increments.
- After bit L of a frame:
  - If frames remain and GAP>0: go to GAP and decrement the frame counter.
  - If frames remain and GAP=0: reload the shift register from the held pattern, stay in SEND, decrement the frame counter.
  - If no frames remain: go to IDLE and assert `done_o` for that one cycle.
- GAP: hold for exactly GAP cycles. Reload the shift register on the final GAP cycle, then go to SEND.
- `start_i` in SEND or GAP is ignored. Input changes after capture have no effect.
- `abort_i` in SEND or GAP: go to IDLE on the next edge. `valid_o` and `data_o` go to 0, and `done_o` is not asserted. `abort_i` in IDLE has no effect.
- `abort_i` and `start_i` together in IDLE: start wins.
- `reset_i` at any time, including mid-frame: next edge gives IDLE with `data_o`=0, `valid_o`=0, `done_o`=0, `ready_o`=1, and all counters 0.
- The bit counter is LW bits wide. The frame counter is 4 bits and counts down; it never wraps.

## Timing
- Every output is a registered or direct state decode. There are no combinational paths from inputs to outputs.
- Start accepted at edge N: the first bit appears at N+1 and bit k at N+k.
- `done_o` is high during the cycle after the last bit. `ready_o` is also 1 in that cycle, so a new `start_i` is accepted back-to-back.
- Total busy cycles = F·L + (F−1)·GAP, where F = `repeat_i`+1.
- Abort latency is 1 cycle.

## Structure
- Shared package `fsm_pkg` holds:
  - the state encodings `ST_IDLE`, `ST_SEND`, `ST_GAP`;
  - the length-saturation rule as a function.
- Single module with no sub-module. The datapath is one shift register, one bit counter, one gap counter and one frame counter.

## Test plan
- WIDTH=8, GAP=2; `pattern_i`=8'hA5, `len_i`=8, `repeat_i`=0 → `data_o` 1,0,1,0,0,1,0,1 with `valid_o`=1 for 8 cycles, then `done_o` for 1 cycle with `ready_o`=1.
- `pattern_i`=8'h06, `len_i`=3, `repeat_i`=1 → 1,1,0, then 2 cycles with `valid_o`=0, then 1,1,0, then `done_o`. Total busy is 8 cycles.
- `len_i`=0 with `pattern_i`=8'h81 → 8 bits, 1,0,0,0,0,0,0,1. `len_i`=15 gives the same result. Repeat with GAP=0 and `repeat_i`=2 → 24 contiguous valid bits.
- `start_i` held high through a transfer → no second capture until `ready_o`. A `start_i` in the `done_o` cycle begins the next frame at the following edge.
- `abort_i` after bit 4 of 8'hFF → `valid_o`=0 on the next cycle, no `done_o`, `ready_o`=1. `reset_i` asserted mid-GAP → all outputs at reset values the next cycle.
- Loopback into a two-bit "11" detector: `pattern_i`=2'b11, `len_i`=2 → detector match asserted exactly once per frame.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared definitions for the serial pattern transmitter: state encodings and
// the frame-length saturation rule.
package fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // A requested length of 0, or one longer than the frame, means a full-width frame.
    function automatic int unsigned sat_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/fsm_pattern_tx.sv
// Serial pattern transmitter: captures a parallel pattern and shifts it out
// MSB-first, repeating the frame with a fixed idle gap between frames.
module fsm_pattern_tx
    import fsm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    parameter int LW    = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [LW-1:0]    len_i,
    input  logic [3:0]       repeat_i,
    input  logic             abort_i,
    output logic             data_o,
    output logic             valid_o,
    output logic             ready_o,
    output logic             done_o
);

    localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pattern_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [LW-1:0]    len_reg;
    logic [LW-1:0]    bit_cnt_reg;
    logic [GW-1:0]    gap_cnt_reg;
    logic [3:0]       frame_cnt_reg;
    logic             done_reg;

    logic             capture, shift_en, reload, gap_start, gap_step, frame_dec, done_next;
    logic [LW-1:0]    cap_len;
    logic             last_bit, gap_last;

    assign cap_len  = LW'(sat_len(32'(len_i), WIDTH));
    assign last_bit = (bit_cnt_reg == len_reg - 1'b1);
    assign gap_last = (gap_cnt_reg == GW'(GAP_LAST));

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        shift_en   = 1'b0;
        reload     = 1'b0;
        gap_start  = 1'b0;
        gap_step   = 1'b0;
        frame_dec  = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_SEND;
                    capture    = 1'b1;
                end
            end
            ST_SEND: begin
                if (abort_i) begin
                    state_next = ST_IDLE;
                end else if (last_bit) begin
                    if (frame_cnt_reg != 4'd0) begin
                        frame_dec = 1'b1;
                        if (GAP > 0) begin
                            state_next = ST_GAP;
                            gap_start  = 1'b1;
                        end else begin
                            reload = 1'b1;
                        end
                    end else begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end else begin
                    shift_en = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort_i) begin
                    state_next = ST_IDLE;
                end else if (gap_last) begin
                    state_next = ST_SEND;
                    reload     = 1'b1;
                end else begin
                    gap_step = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg     <= ST_IDLE;
            pattern_reg   <= '0;
            shift_reg     <= '0;
            len_reg       <= '0;
            bit_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            frame_cnt_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            // Left-align the frame so the shift register MSB is always the next bit out.
            if (capture) begin
                pattern_reg   <= pattern_i;
                len_reg       <= cap_len;
                frame_cnt_reg <= repeat_i;
                shift_reg     <= pattern_i << (LW'(WIDTH) - cap_len);
                bit_cnt_reg   <= '0;
            end else if (reload) begin
                shift_reg   <= pattern_reg << (LW'(WIDTH) - len_reg);
                bit_cnt_reg <= '0;
            end else if (shift_en) begin
                shift_reg   <= shift_reg << 1;
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            if (frame_dec) begin
                frame_cnt_reg <= frame_cnt_reg - 1'b1;
            end
            if (gap_start) begin
                gap_cnt_reg <= '0;
            end else if (gap_step) begin
                gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
        end
    end

    assign valid_o = (state_reg == ST_SEND);
    assign data_o  = valid_o & shift_reg[WIDTH-1];
    assign ready_o = (state_reg == ST_IDLE);
    assign done_o  = done_reg;

endmodule

// File: tb/tb_fsm_pattern_tx.sv
// Scoreboard bench for fsm_pattern_tx: one instance with GAP=2, one with GAP=0.
module tb_fsm_pattern_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] len = 4'd0;
    logic [3:0] rep_in = 4'd0;
    logic       abort = 1'b0;
    logic       data0, valid0, ready0, done0;
    logic       data1, valid1, ready1, done1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fsm_pattern_tx #(.WIDTH(8), .GAP(2)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start0), .pattern_i(pattern),
        .len_i(len), .repeat_i(rep_in), .abort_i(abort),
        .data_o(data0), .valid_o(valid0), .ready_o(ready0), .done_o(done0)
    );

    fsm_pattern_tx #(.WIDTH(8), .GAP(0)) dut_g0 (
        .clk_i(clk), .reset_i(reset), .start_i(start1), .pattern_i(pattern),
        .len_i(len), .repeat_i(rep_in), .abort_i(abort),
        .data_o(data1), .valid_o(valid1), .ready_o(ready1), .done_o(done1)
    );

    typedef struct {
        int   t;
        logic v;
        logic d;
        logic dn;
        logic r;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    function automatic void push(input int id, input int t, input logic v, input logic d,
                                 input logic dn, input logic r);
        exp_t e;
        e.t = t; e.v = v; e.d = d; e.dn = dn; e.r = r;
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic int tb_len(input logic [3:0] ln);
        return ((ln == 0) || (ln > 8)) ? 8 : int'(ln);
    endfunction

    // Expected per-cycle trace of a full transfer; returns the stamp of the done cycle.
    function automatic int push_frames(input int id, input int t0, input logic [7:0] pat,
                                       input int nbits, input int nframes, input int gap);
        int t = t0;
        for (int f = 0; f < nframes; f++) begin
            for (int k = nbits - 1; k >= 0; k--) begin
                push(id, t, 1'b1, pat[k], 1'b0, 1'b0);
                t++;
            end
            if (f < nframes - 1) begin
                for (int g = 0; g < gap; g++) begin
                    push(id, t, 1'b0, 1'b0, 1'b0, 1'b0);
                    t++;
                end
            end
        end
        push(id, t, 1'b0, 1'b0, 1'b1, 1'b1);
        return t;
    endfunction

    task automatic cmp(input string nm, input int id, input logic v, input logic d,
                       input logic dn, input logic r, input logic ev, input logic ed,
                       input logic edn, input logic er);
        checks++;
        if ({v, d, dn, r} !== {ev, ed, edn, er}) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got valid=%b data=%b done=%b ready=%b expected valid=%b data=%b done=%b ready=%b",
                     nm, id, cyc, v, d, dn, r, ev, ed, edn, er);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, want);
        end
    endtask

    // Monitor: every cycle either consumes the expected entry for this cycle or expects idle.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (q0.size() > 0 && q0[0].t == cyc) begin
                e0 = q0.pop_front();
                cmp("sb", 0, valid0, data0, done0, ready0, e0.v, e0.d, e0.dn, e0.r);
            end else begin
                cmp("idle", 0, valid0, data0, done0, ready0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            if (q1.size() > 0 && q1[0].t == cyc) begin
                e1 = q1.pop_front();
                cmp("sb", 1, valid1, data1, done1, ready1, e1.v, e1.d, e1.dn, e1.r);
            end else begin
                cmp("idle", 1, valid1, data1, done1, ready1, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end
    end

    int busy_cnt = 0;
    int match_cnt = 0;
    logic det_last = 1'b0;

    // Busy-cycle counter and a two-bit "11" detector fed from the GAP=2 instance.
    always @(negedge clk) begin
        if (!ready0) busy_cnt <= busy_cnt + 1;
        if (valid0 && data0 && det_last) match_cnt <= match_cnt + 1;
        det_last <= valid0 && data0;
    end

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 300 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout pending=%0d expected pending=0", nm, q0.size() + q1.size());
            q0.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_tx(input int id, input logic [7:0] pat, input logic [3:0] ln,
                          input logic [3:0] rep, input int gap, input logic with_abort,
                          input string nm);
        int td;
        @(negedge clk);
        pattern = pat; len = ln; rep_in = rep; abort = with_abort;
        if (id == 0) start0 = 1'b1;
        else start1 = 1'b1;
        td = push_frames(id, cyc + 1, pat, tb_len(ln), int'(rep) + 1, gap);
        @(negedge clk);
        // Scramble inputs after capture; the transfer must not notice.
        start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
        pattern = ~pat; len = 4'd1; rep_in = 4'd9;
        wait_drain(nm);
        $display("tx %s: dut%0d pattern=%h len=%0d repeat=%0d done_at=%0d", nm, id, pat, ln, rep, td);
    endtask

    initial begin
        int base, td, td2, snap, msnap;

        @(negedge clk);
        push(0, cyc + 1, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1, cyc + 1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        wait_drain("reset");
        $display("tx reset: both instances idle");

        snap = busy_cnt;
        run_tx(0, 8'hA5, 4'd8, 4'd0, 2, 1'b0, "a5_len8");
        chk_int("busy_a5", busy_cnt - snap, 8);

        snap = busy_cnt;
        run_tx(0, 8'h06, 4'd3, 4'd1, 2, 1'b0, "06_len3_rep1");
        chk_int("busy_06_rep1", busy_cnt - snap, 8);

        run_tx(0, 8'h81, 4'd0, 4'd0, 2, 1'b0, "81_len0");
        run_tx(0, 8'h81, 4'd15, 4'd0, 2, 1'b0, "81_len15");
        run_tx(1, 8'h81, 4'd0, 4'd2, 0, 1'b0, "81_gap0_rep2");
        run_tx(1, 8'h06, 4'd3, 4'd1, 0, 1'b0, "06_gap0_rep1");
        run_tx(0, 8'h5A, 4'd2, 4'd0, 2, 1'b1, "start_abort_idle");

        // start_i held high: ignored while busy, accepted again in the done cycle.
        @(negedge clk);
        pattern = 8'hC5; len = 4'd4; rep_in = 4'd0; start0 = 1'b1;
        td  = push_frames(0, cyc + 1, 8'hC5, 4, 1, 2);
        td2 = push_frames(0, td + 1, 8'hC5, 4, 1, 2);
        for (int i = 0; i < 100 && cyc < td + 1; i++) @(negedge clk);
        start0 = 1'b0;
        wait_drain("start_held");
        $display("tx start_held: two frames, second done_at=%0d", td2);

        // Abort while bit 4 of 8'hFF is on the line.
        @(negedge clk);
        pattern = 8'hFF; len = 4'd8; rep_in = 4'd0; start0 = 1'b1;
        base = cyc + 1;
        for (int k = 0; k < 4; k++) push(0, base + k, 1'b1, 1'b1, 1'b0, 1'b0);
        push(0, base + 4, 1'b0, 1'b0, 1'b0, 1'b1);
        push(0, base + 5, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 100 && cyc < base + 3; i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_drain("abort");
        $display("tx abort: FF aborted after 4 bits");

        // Reset during the first gap cycle of a repeated frame.
        @(negedge clk);
        pattern = 8'h06; len = 4'd3; rep_in = 4'd1; start0 = 1'b1;
        base = cyc + 1;
        push(0, base,     1'b1, 1'b1, 1'b0, 1'b0);
        push(0, base + 1, 1'b1, 1'b1, 1'b0, 1'b0);
        push(0, base + 2, 1'b1, 1'b0, 1'b0, 1'b0);
        push(0, base + 3, 1'b0, 1'b0, 1'b0, 1'b0);
        push(0, base + 4, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 100 && cyc < base + 3; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_drain("reset_mid_gap");
        $display("tx reset_mid_gap: outputs back to reset values");

        snap = busy_cnt;
        run_tx(0, 8'hA5, 4'd8, 4'd0, 2, 1'b0, "a5_after_reset");
        chk_int("busy_a5_after_reset", busy_cnt - snap, 8);

        msnap = match_cnt;
        run_tx(0, 8'h03, 4'd2, 4'd2, 2, 1'b0, "loop11");
        chk_int("detector_11_matches", match_cnt - msnap, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
